// File: rtl/dtlb_miss_resp_pkg.sv
// Shared widths and walker state encoding for the dTLB miss-response block.
package dtlb_miss_resp_pkg;

  localparam int DTLB_ADDR_WIDTH = 30;  // VA[43:14]
  localparam int DTLB_DATA_WIDTH = 64;

  typedef enum logic [1:0] {
    WALK_IDLE = 2'd0,
    WALK_REQ  = 2'd1,
    WALK_WAIT = 2'd2
  } walk_state_e;

endpackage

// File: rtl/dtlb_miss_resp_if.sv
// Miss-request, page-walk and dTLB-fill signals of dtlb_miss_resp, grouped as one bundle.
interface dtlb_miss_resp_if
  import dtlb_miss_resp_pkg::*;
#(
  parameter int ADDR_WIDTH = DTLB_ADDR_WIDTH,
  parameter int TLB_DWIDTH = DTLB_DATA_WIDTH
);

  logic                  tlbreq_en;
  logic [ADDR_WIDTH-1:0] tlbreq_addr;
  logic                  tlbreq_ack;
  logic                  flush;
  logic                  walk_req;
  logic [ADDR_WIDTH-1:0] walk_addr;
  logic                  walk_rdy;
  logic                  walk_resp_en;
  logic [TLB_DWIDTH-1:0] walk_resp_data;
  logic                  walk_resp_fault;
  logic                  tlbfill_en;
  logic [ADDR_WIDTH-1:0] tlbfill_addr;
  logic [TLB_DWIDTH-1:0] tlbfill_data;
  logic                  tlbfill_fault;
  logic                  busy;

  modport slave (
    input  tlbreq_en, tlbreq_addr, flush, walk_rdy,
           walk_resp_en, walk_resp_data, walk_resp_fault,
    output tlbreq_ack, walk_req, walk_addr,
           tlbfill_en, tlbfill_addr, tlbfill_data, tlbfill_fault, busy
  );

  modport master (
    output tlbreq_en, tlbreq_addr, flush, walk_rdy,
           walk_resp_en, walk_resp_data, walk_resp_fault,
    input  tlbreq_ack, walk_req, walk_addr,
           tlbfill_en, tlbfill_addr, tlbfill_data, tlbfill_fault, busy
  );

endinterface

// File: rtl/dtlb_mq_cam.sv
// Parallel page-address compare against every valid request-queue entry.
module dtlb_mq_cam #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 30
) (
  input  logic [DEPTH-1:0]                 valid_i,
  input  logic [DEPTH-1:0][ADDR_WIDTH-1:0] addr_i,
  input  logic [ADDR_WIDTH-1:0]            key_i,
  output logic [DEPTH-1:0]                 match_o
);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      match_o[i] = valid_i[i] && (addr_i[i] == key_i);
    end
  end

endmodule

// File: rtl/dtlb_miss_resp.sv
// dTLB miss queue: merges duplicate misses, issues one page walk at a time
// and turns each walk response into a registered one-cycle dTLB fill.
module dtlb_miss_resp
  import dtlb_miss_resp_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = DTLB_ADDR_WIDTH,
  parameter int TLB_DWIDTH = DTLB_DATA_WIDTH
) (
  input logic             clk,
  input logic             rst,
  dtlb_miss_resp_if.slave mr_if
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]                 valid_q, valid_d, issued_q, issued_d;
  logic [DEPTH-1:0][ADDR_WIDTH-1:0] addr_q;
  logic [PW-1:0]                    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]                    count_q, count_d;
  walk_state_e                      state_q, state_d;

  logic [DEPTH-1:0] match_vec;
  logic             match, full, pop, handoff, ack, alloc;

  logic                  fill_en_q, fill_fault_q;
  logic [ADDR_WIDTH-1:0] fill_addr_q;
  logic [TLB_DWIDTH-1:0] fill_data_q;

  dtlb_mq_cam #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_cam (
    .valid_i (valid_q),
    .addr_i  (addr_q),
    .key_i   (mr_if.tlbreq_addr),
    .match_o (match_vec)
  );

  assign match   = |match_vec;
  assign full    = (count_q == CW'(DEPTH));
  assign pop     = (state_q == WALK_WAIT) && mr_if.walk_resp_en;
  assign handoff = (state_q == WALK_REQ) && mr_if.walk_rdy;
  // Gated by rst so the combinational ack stays low throughout reset.
  assign ack     = rst && mr_if.tlbreq_en && !mr_if.flush && (match || !full || pop);
  assign alloc   = ack && !match;

  // NOTE: every always_comb target gets its default first so no path leaves it unassigned (no latch).
  always_comb begin
    valid_d  = valid_q;
    issued_d = issued_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q + CW'(alloc) - CW'(pop);
    if (handoff) issued_d[head_q] = 1'b1;
    if (pop) begin
      valid_d[head_q]  = 1'b0;
      issued_d[head_q] = 1'b0;
      head_d           = head_q + PW'(1);
    end
    // On a full queue with a pop, tail == head: the new entry reuses the freed slot.
    if (alloc) begin
      valid_d[tail_q]  = 1'b1;
      issued_d[tail_q] = 1'b0;
      tail_d           = tail_q + PW'(1);
    end
    // Only the head can be issued, so a flush leaves at most that one entry.
    if (mr_if.flush) begin
      valid_d  = valid_d & issued_d;
      issued_d = issued_d & valid_d;
      count_d  = CW'(valid_d[head_d]);
      tail_d   = head_d + PW'(valid_d[head_d]);
    end
  end

  always_comb begin
    state_d        = state_q;
    mr_if.walk_req = 1'b0;
    unique case (state_q)
      WALK_IDLE: if (valid_d[head_d] && !issued_d[head_d]) state_d = WALK_REQ;
      WALK_REQ: begin
        mr_if.walk_req = 1'b1;
        if (handoff)           state_d = WALK_WAIT;
        else if (mr_if.flush)  state_d = WALK_IDLE;
      end
      WALK_WAIT: if (mr_if.walk_resp_en) state_d = WALK_IDLE;
      default:   state_d = WALK_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= '0;
      issued_q <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      state_q  <= WALK_IDLE;
    end else begin
      valid_q  <= valid_d;
      issued_q <= issued_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      state_q  <= state_d;
    end
  end

  // NOTE: the address array has no reset; valid_q qualifies every read of it.
  always_ff @(posedge clk) begin
    if (alloc) addr_q[tail_q] <= mr_if.tlbreq_addr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_en_q    <= 1'b0;
      fill_fault_q <= 1'b0;
      fill_addr_q  <= '0;
      fill_data_q  <= '0;
    end else begin
      fill_en_q    <= pop;
      fill_fault_q <= pop && mr_if.walk_resp_fault;
      if (pop) begin
        fill_addr_q <= addr_q[head_q];
        fill_data_q <= mr_if.walk_resp_data;
      end
    end
  end

  assign mr_if.tlbreq_ack    = ack;
  assign mr_if.walk_addr     = addr_q[head_q];
  assign mr_if.tlbfill_en    = fill_en_q;
  assign mr_if.tlbfill_addr  = fill_addr_q;
  assign mr_if.tlbfill_data  = fill_data_q;
  assign mr_if.tlbfill_fault = fill_fault_q;
  assign mr_if.busy          = (count_q != '0) || (state_q != WALK_IDLE);

endmodule

// File: tb/tb_dtlb_miss_resp.sv
// Randomized and directed bench for dtlb_miss_resp against a queue-based reference model.
module tb_dtlb_miss_resp;

  localparam int DEPTH = 4;
  localparam int AW    = 30;
  localparam int DW    = 64;

  typedef struct {
    logic [AW-1:0] addr;
    bit            issued;
  } ent_t;

  logic clk;
  logic rst_n;

  dtlb_miss_resp_if #(.ADDR_WIDTH(AW), .TLB_DWIDTH(DW)) mr ();

  dtlb_miss_resp #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW),
    .TLB_DWIDTH (DW)
  ) dut (
    .clk   (clk),
    .rst   (rst_n),
    .mr_if (mr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: outstanding misses in arrival order plus walker/fill bookkeeping.
  ent_t          mq[$];
  bit            m_req, m_wait, m_fill, m_fill_fault;
  logic [AW-1:0] m_fill_addr;
  logic [DW-1:0] m_fill_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input bit en, input logic [AW-1:0] a, input bit fl, input bit rdy,
                       input bit rsp, input logic [DW-1:0] d, input bit flt);
    mr.tlbreq_en       = en;
    mr.tlbreq_addr     = a;
    mr.flush           = fl;
    mr.walk_rdy        = rdy;
    mr.walk_resp_en    = rsp;
    mr.walk_resp_data  = d;
    mr.walk_resp_fault = flt;
  endtask

  task automatic model_clear();
    mq.delete();
    m_req = 0; m_wait = 0; m_fill = 0; m_fill_fault = 0;
    m_fill_addr = '0; m_fill_data = '0;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input bit en, input logic [AW-1:0] a, input bit fl, input bit rdy,
                       input bit rsp, input logic [DW-1:0] d, input bit flt);
    bit   hit, pop, ack_exp;
    ent_t keep[$];
    drive(en, a, fl, rdy, rsp, d, flt);
    #1;
    hit = 0;
    foreach (mq[i]) if (mq[i].addr == a) hit = 1;
    pop     = m_wait && rsp;
    ack_exp = en && !fl && (hit || (mq.size() < DEPTH) || pop);
    check("tlbreq_ack", 64'(mr.tlbreq_ack), 64'(ack_exp));
    check("walk_req", 64'(mr.walk_req), 64'(m_req));
    if (m_req) check("walk_addr", 64'(mr.walk_addr), 64'(mq[0].addr));
    check("busy", 64'(mr.busy), 64'((mq.size() != 0) || m_req || m_wait));
    check("tlbfill_en", 64'(mr.tlbfill_en), 64'(m_fill));
    if (m_fill) begin
      check("tlbfill_addr", 64'(mr.tlbfill_addr), 64'(m_fill_addr));
      check("tlbfill_data", mr.tlbfill_data, m_fill_data);
      check("tlbfill_fault", 64'(mr.tlbfill_fault), 64'(m_fill_fault));
    end
    @(posedge clk);
    m_fill = pop;
    if (pop) begin
      m_fill_addr  = mq[0].addr;
      m_fill_data  = d;
      m_fill_fault = flt;
    end
    if (m_req && rdy) mq[0].issued = 1;
    if (pop) void'(mq.pop_front());
    if (ack_exp && !hit) mq.push_back('{a, 1'b0});
    if (fl) begin
      foreach (mq[i]) if (mq[i].issued) keep.push_back(mq[i]);
      mq = keep;
    end
    if (m_wait) begin
      if (rsp) m_wait = 0;
    end else if (m_req) begin
      if (rdy) begin m_req = 0; m_wait = 1; end
      else if (fl) m_req = 0;
    end else if (mq.size() != 0 && !mq[0].issued) begin
      m_req = 1;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, '0, 0, 0, 0, '0, 0);
  endtask

  // Asserts reset at a falling edge with busy-looking inputs and checks every forced output.
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    drive(1, AW'(32'h1000), 0, 1, 1, {$urandom, $urandom}, 1);
    for (int i = 0; i < n; i++) begin
      #1;
      check("rst_ack", 64'(mr.tlbreq_ack), 64'(0));
      check("rst_walk_req", 64'(mr.walk_req), 64'(0));
      check("rst_fill_en", 64'(mr.tlbfill_en), 64'(0));
      check("rst_fill_fault", 64'(mr.tlbfill_fault), 64'(0));
      check("rst_busy", 64'(mr.busy), 64'(0));
      check("rst_fill_addr", 64'(mr.tlbfill_addr), 64'(0));
      check("rst_fill_data", mr.tlbfill_data, 64'(0));
      @(negedge clk);
    end
    model_clear();
    drive(0, '0, 0, 0, 0, '0, 0);
    rst_n = 1'b1;
  endtask

  localparam logic [DW-1:0] D1 = 64'hDEAD_BEEF_0123_4567;

  initial begin
    rst_n = 1'b0;
    drive(0, '0, 0, 0, 0, '0, 0);
    model_clear();
    @(negedge clk);
    do_reset(2);

    // Single miss on an empty queue, accepted on the first edge after reset.
    cycle(1, AW'(32'h1000), 0, 0, 0, '0, 0);
    cycle(0, '0, 0, 1, 0, '0, 0);
    cycle(0, '0, 0, 0, 1, D1, 0);
    idle(2);

    // Fill the queue, refuse a fifth distinct page, merge a duplicate.
    cycle(1, AW'(32'h2000), 0, 0, 0, '0, 0);
    cycle(1, AW'(32'h2001), 0, 0, 0, '0, 0);
    cycle(1, AW'(32'h2002), 0, 0, 0, '0, 0);
    cycle(1, AW'(32'h2003), 0, 0, 0, '0, 0);
    cycle(1, AW'(32'h2004), 0, 0, 0, '0, 0);
    cycle(1, AW'(32'h2001), 0, 0, 0, '0, 0);
    cycle(1, AW'(32'h2004), 0, 0, 0, '0, 0);
    // Full queue: a distinct page coincident with the walk response is accepted.
    cycle(0, '0, 0, 1, 0, '0, 0);
    cycle(1, AW'(32'h2004), 0, 0, 1, {$urandom, $urandom}, 0);
    cycle(1, AW'(32'h2005), 0, 0, 0, '0, 0);
    // A flush also refuses the request presented with it.
    cycle(1, AW'(32'h2006), 1, 0, 0, '0, 0);
    idle(3);

    // Three queued, head issued, flush: only the head's fill follows.
    cycle(1, AW'(32'h3000), 0, 0, 0, '0, 0);
    cycle(1, AW'(32'h3001), 0, 1, 0, '0, 0);
    cycle(1, AW'(32'h3002), 0, 0, 0, '0, 0);
    cycle(1, AW'(32'h3003), 1, 0, 0, '0, 0);
    idle(2);
    cycle(0, '0, 0, 0, 1, {$urandom, $urandom}, 0);
    idle(4);

    // Faulting walk, then the next entry is walked.
    cycle(1, AW'(32'h4000), 0, 0, 0, '0, 0);
    cycle(1, AW'(32'h4001), 0, 1, 0, '0, 0);
    cycle(0, '0, 0, 0, 1, {$urandom, $urandom}, 1);
    idle(2);
    cycle(0, '0, 0, 1, 0, '0, 0);
    cycle(0, '0, 0, 0, 1, {$urandom, $urandom}, 0);
    idle(2);

    // Reset in the middle of a walk; the stray response afterwards is ignored.
    cycle(1, AW'(32'h5000), 0, 0, 0, '0, 0);
    cycle(0, '0, 0, 1, 0, '0, 0);
    idle(1);
    do_reset(1);
    cycle(0, '0, 0, 0, 1, {$urandom, $urandom}, 1);
    idle(2);

    // Random traffic over a small page pool so merges and full-queue cases recur.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset(1);
      end else begin
        cycle($urandom_range(0, 1) == 1,
              AW'(32'h6000 + $urandom_range(0, 5)),
              $urandom_range(0, 19) == 0,
              $urandom_range(0, 9) < 4,
              $urandom_range(0, 9) < 3,
              {$urandom, $urandom},
              $urandom_range(0, 3) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dtlb_miss_resp.md
DTLB_MISS_RESP -- requirements
Module: dtlb_miss_resp

Interface
REQ-001 SHALL have parameter DEPTH, 4, request-queue entries (power of two).
REQ-002 SHALL have parameter ADDR_WIDTH, 30, virtual page number width (VA[43:14]).
REQ-003 SHALL have parameter TLB_DWIDTH, `dtlbData_width, fill payload width.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port tlbreq_en  in  1  single-cycle miss request from the store/load TLB-miss replay buffer.
REQ-007 SHALL have port tlbreq_addr  in  ADDR_WIDTH  requested page.
REQ-008 SHALL have port tlbreq_ack  out  1  same-cycle acceptance of tlbreq_en.
REQ-009 SHALL have port flush  in  1  drop unissued queued requests.
REQ-010 SHALL have port walk_req  out  1  walk request valid.
REQ-011 SHALL have port walk_addr  out  ADDR_WIDTH  page to walk.
REQ-012 SHALL have port walk_rdy  in  1  walker accepts walk_req.
REQ-013 SHALL have port walk_resp_en  in  1  walk result valid.
REQ-014 SHALL have port walk_resp_data  in  TLB_DWIDTH  translation.
REQ-015 SHALL have port walk_resp_fault  in  1  walk faulted.
REQ-016 SHALL have port tlbfill_en  out  1  fill dTLB.
REQ-017 SHALL have port tlbfill_addr  out  ADDR_WIDTH  filled page.
REQ-018 SHALL have port tlbfill_data  out  TLB_DWIDTH  fill payload.
REQ-019 SHALL have port tlbfill_fault  out  1  fill carries fault.
REQ-020 SHALL have port busy  out  1  queue non-empty or walk outstanding.

Function
REQ-021 SHALL hold requests in a DEPTH-entry FIFO (valid, addr, issued bit), head/tail pointers wrapping modulo DEPTH, count 0..DEPTH.
REQ-022 SHALL drive tlbreq_ack combinationally = tlbreq_en & (match | ~full | pop_this_cycle); no request is acked later than its en cycle.
REQ-023 SHALL set match when tlbreq_addr equals the addr of any valid entry; matched requests are acked without allocation (merge).
REQ-024 SHALL allocate at tail on acked, non-matched tlbreq_en; count increments unless a pop occurs the same cycle.
REQ-025 SHALL keep walker FSM states IDLE, REQ, WAIT: IDLE->REQ when head valid and not issued; REQ holds walk_req=1, walk_addr=head addr until walk_rdy, then sets head issued and ->WAIT; WAIT->IDLE on walk_resp_en.
REQ-026 SHALL allow exactly one outstanding walk.
REQ-027 SHALL on walk_resp_en pop the head and, one cycle later, pulse tlbfill_en=1 for one cycle with head addr, walk_resp_data, walk_resp_fault registered.
REQ-028 SHALL treat a tlbreq_en whose addr equals the head addr during walk_resp_en cycle as matched (acked, not allocated).
REQ-029 SHALL on flush invalidate all unissued entries in one cycle; an issued head stays and its fill is still delivered; flush in REQ state before walk_rdy returns FSM to IDLE and drops the head.
REQ-030 SHALL not ack tlbreq_en in a flush cycle.
REQ-031 SHALL, with full queue and no pop, drive tlbreq_ack=0 unless matched.
REQ-032 SHALL ignore walk_resp_en in IDLE/REQ (no pop, no fill).
REQ-033 SHALL drive busy = (count!=0) | (state!=IDLE).

Reset
REQ-034 SHALL, while rst=0, force tlbreq_ack=0, walk_req=0, tlbfill_en=0, tlbfill_fault=0, busy=0, tlbfill_addr/data=0, count=0, pointers=0, all valid=0, FSM=IDLE.
REQ-035 SHALL on reset mid-walk discard outstanding walk; a later walk_resp_en is ignored per REQ-032.
REQ-036 SHALL accept requests from the first rising edge after rst deasserts.

Structure
REQ-037 SHALL take TLB_DWIDTH and ADDR_WIDTH from the shared struct.sv defines; FSM state encoding in the shared package.
REQ-038 SHALL instantiate one sub-module dtlb_mq_cam (DEPTH-entry valid/addr match array returning match vector).

Verification
REQ-039 SHALL cover: en addr=0x1000 on empty -> ack same cycle, walk_req next cycle addr 0x1000; rdy, resp data=D -> tlbfill_en one cycle later, addr 0x1000, data D, busy drops.
REQ-040 SHALL cover: 4 distinct requests then 5th distinct -> 5th ack=0; 5th equal to entry 2 -> ack=1, count stays 4.
REQ-041 SHALL cover: full queue, 5th distinct en coincident with walk_resp_en -> ack=1, count stays 4.
REQ-042 SHALL cover: 3 queued, head issued, flush -> count=1, fill for head delivered, no further walk_req.
REQ-043 SHALL cover: walk_resp_fault=1 -> tlbfill_fault=1, head popped, next entry walked.
REQ-044 SHALL cover: rst asserted in WAIT, released, stray walk_resp_en -> no tlbfill_en, busy=0.
